// File: rtl/data_sram_req_pkg.sv
// Shared definitions for the data-side SRAM request initiator:
// mem op encodings, address-error exccodes and FSM state encoding.
package data_sram_req_pkg;

    localparam logic [2:0] OP_W  = 3'd0;
    localparam logic [2:0] OP_B  = 3'd1;
    localparam logic [2:0] OP_BU = 3'd2;
    localparam logic [2:0] OP_H  = 3'd3;
    localparam logic [2:0] OP_HU = 3'd4;
    localparam logic [2:0] OP_WL = 3'd5;
    localparam logic [2:0] OP_WR = 3'd6;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/data_sram_req_store_fmt.sv
// Request formatter: op + address + rt -> size, address, byte strobes and data.
// Loads leave wstrb/wdata at zero; WL/WR always use the word-aligned address.
module data_sram_req_store_fmt #(
    parameter int ADDR_W = 32
) (
    input  logic              we_i,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       rt_i,
    output logic [1:0]        size_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [3:0]        wstrb_o,
    output logic [31:0]       wdata_o
);
    import data_sram_req_pkg::*;

    logic [1:0]        a;
    logic [ADDR_W-1:0] addr_al;

    assign a       = addr_i[1:0];
    assign addr_al = {addr_i[ADDR_W-1:2], 2'b00};

    always_comb begin
        size_o  = 2'd2;
        addr_o  = addr_i;
        wstrb_o = 4'b0000;
        wdata_o = 32'h0;
        unique case (op_i)
            OP_B, OP_BU: begin
                size_o = 2'd0;
                if (we_i) begin
                    wstrb_o = 4'b0001 << a;
                    wdata_o = {4{rt_i[7:0]}};
                end
            end
            OP_H, OP_HU: begin
                size_o = 2'd1;
                if (we_i) begin
                    wstrb_o = a[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{rt_i[15:0]}};
                end
            end
            OP_WL: begin
                addr_o = addr_al;
                if (we_i) begin
                    unique case (a)
                        2'd0: begin wstrb_o = 4'b0001; wdata_o = {24'h0, rt_i[31:24]}; end
                        2'd1: begin wstrb_o = 4'b0011; wdata_o = {16'h0, rt_i[31:16]}; end
                        2'd2: begin wstrb_o = 4'b0111; wdata_o = {8'h0, rt_i[31:8]}; end
                        default: begin wstrb_o = 4'b1111; wdata_o = rt_i; end
                    endcase
                end
            end
            OP_WR: begin
                addr_o = addr_al;
                if (we_i) begin
                    unique case (a)
                        2'd0: begin wstrb_o = 4'b1111; wdata_o = rt_i; end
                        2'd1: begin wstrb_o = 4'b1110; wdata_o = {rt_i[23:0], 8'h0}; end
                        2'd2: begin wstrb_o = 4'b1100; wdata_o = {rt_i[15:0], 16'h0}; end
                        default: begin wstrb_o = 4'b1000; wdata_o = {rt_i[7:0], 24'h0}; end
                    endcase
                end
            end
            default: begin
                if (we_i) begin
                    wstrb_o = 4'b1111;
                    wdata_o = rt_i;
                end
            end
        endcase
    end

endmodule

// File: rtl/data_sram_req.sv
// EX/MEM data-side SRAM request initiator with single outstanding transaction.
// Define ADDR_CHECK_EN to raise AdEL/AdES for misaligned H/HU/W accesses.
module data_sram_req #(
    parameter int         ADDR_W   = 32,
    parameter logic [4:0] EXC_ADEL = data_sram_req_pkg::EXC_ADEL,
    parameter logic [4:0] EXC_ADES = data_sram_req_pkg::EXC_ADES
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_mem_valid,
    input  logic              es_mem_we,
    input  logic [2:0]        es_mem_op,
    input  logic [ADDR_W-1:0] es_addr,
    input  logic [31:0]       es_st_data,
    input  logic              es_ex,
    input  logic              flush,
    input  logic              ms_allowin,
    output logic              mem_ready_go,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    output logic              resp_valid,
    output logic              adr_ex,
    output logic [4:0]        adr_exccode
);
    import data_sram_req_pkg::*;

    state_e            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              issued_q, issued_d;
    logic              resp_q, resp_d;
    logic              wr_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       wdata_q;

    logic [1:0]        fmt_size;
    logic [ADDR_W-1:0] fmt_addr;
    logic [3:0]        fmt_wstrb;
    logic [31:0]       fmt_wdata;
    logic [4:0]        code;
    logic              launch;
    logic              addr_hs;

    data_sram_req_store_fmt #(.ADDR_W(ADDR_W)) u_fmt (
        .we_i    (es_mem_we),
        .op_i    (es_mem_op),
        .addr_i  (es_addr),
        .rt_i    (es_st_data),
        .size_o  (fmt_size),
        .addr_o  (fmt_addr),
        .wstrb_o (fmt_wstrb),
        .wdata_o (fmt_wdata)
    );

    assign code = es_mem_we ? EXC_ADES : EXC_ADEL;

`ifdef ADDR_CHECK_EN
    logic misal;
    assign misal = (((es_mem_op == OP_H) | (es_mem_op == OP_HU)) & es_addr[0])
                 | ((es_mem_op == OP_W) & (es_addr[1:0] != 2'b00));
    assign adr_ex      = es_mem_valid & ~es_ex & misal;
    assign adr_exccode = code;
`else
    assign adr_ex      = 1'b0;
    assign adr_exccode = code & {5{adr_ex}};
`endif

    assign launch  = es_mem_valid & ~es_ex & ~flush & ~issued_q & ~adr_ex
                   & (state_q == ST_IDLE);
    assign addr_hs = (state_q == ST_REQ) & data_addr_ok;

    assign mem_ready_go = ~es_mem_valid | es_ex | adr_ex | issued_q | addr_hs;
    assign data_req     = (state_q == ST_REQ);
    assign data_wr      = wr_q;
    assign data_size    = size_q;
    assign data_addr    = addr_q;
    assign data_wstrb   = wstrb_q;
    assign data_wdata   = wdata_q;
    assign resp_valid   = resp_q;

    // A flushed transaction still finishes on the bus; only its response is dropped.
    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        resp_d   = 1'b0;
        issued_d = issued_q;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (flush) cancel_d = 1'b1;
                if (data_addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) cancel_d = 1'b1;
                if (data_data_ok) begin
                    state_d  = ST_IDLE;
                    resp_d   = ~cancel_q & ~flush;
                    cancel_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush | ms_allowin) issued_d = 1'b0;
        else if (addr_hs)       issued_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cancel_q <= 1'b0;
            issued_q <= 1'b0;
            resp_q   <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wstrb_q  <= 4'b0000;
            wdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
            issued_q <= issued_d;
            resp_q   <= resp_d;
            if (launch) begin
                wr_q    <= es_mem_we;
                size_q  <= fmt_size;
                addr_q  <= fmt_addr;
                wstrb_q <= fmt_wstrb;
                wdata_q <= fmt_wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_req.sv
// Scoreboard bench for data_sram_req: directed scenarios plus randomized
// loads/stores against a behavioural request/response model.
module tb_data_sram_req;
    import data_sram_req_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_mem_valid;
    logic        es_mem_we;
    logic [2:0]  es_mem_op;
    logic [31:0] es_addr;
    logic [31:0] es_st_data;
    logic        es_ex;
    logic        flush;
    logic        ms_allowin;
    logic        mem_ready_go;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        resp_valid;
    logic        adr_ex;
    logic [4:0]  adr_exccode;

    always #5 clk = ~clk;

    data_sram_req #(.ADDR_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .es_mem_valid (es_mem_valid),
        .es_mem_we    (es_mem_we),
        .es_mem_op    (es_mem_op),
        .es_addr      (es_addr),
        .es_st_data   (es_st_data),
        .es_ex        (es_ex),
        .flush        (flush),
        .ms_allowin   (ms_allowin),
        .mem_ready_go (mem_ready_go),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .resp_valid   (resp_valid),
        .adr_ex       (adr_ex),
        .adr_exccode  (adr_exccode)
    );

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    exp_t req_q[$];
    bit   resp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   addr_dly = 0;
    int   data_dly = 0;
    int   last_req_len = 0;
    bit   outst = 1'b0;
    bit   armed = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event never happened", name);
    endtask

    // Expected request derived from the op semantics as byte-lane arithmetic.
    function automatic exp_t model(input bit we, input int op, input logic [31:0] addr,
                                   input logic [31:0] rt);
        exp_t e;
        int a;
        a = int'(addr[1:0]);
        e.wr    = we;
        e.addr  = addr;
        e.wstrb = 4'h0;
        e.wdata = 32'h0;
        if (op == 1 || op == 2)      e.size = 2'd0;
        else if (op == 3 || op == 4) e.size = 2'd1;
        else                         e.size = 2'd2;
        if (op == 5 || op == 6) e.addr = addr - 32'(a);
        if (we) begin
            if (op == 1 || op == 2) begin
                e.wstrb = 4'(1 << a);
                e.wdata = 32'(rt[7:0]) * 32'h01010101;
            end else if (op == 3 || op == 4) begin
                e.wstrb = (a >= 2) ? 4'hC : 4'h3;
                e.wdata = 32'(rt[15:0]) * 32'h00010001;
            end else if (op == 5) begin
                e.wstrb = 4'((1 << (a + 1)) - 1);
                e.wdata = rt >> (8 * (3 - a));
            end else if (op == 6) begin
                e.wstrb = 4'(15 << a);
                e.wdata = rt << (8 * a);
            end else begin
                e.wstrb = 4'hF;
                e.wdata = rt;
            end
        end
        return e;
    endfunction

    function automatic bit exp_adr(input bit ex, input int op, input logic [31:0] addr);
`ifdef ADDR_CHECK_EN
        return !ex && ((((op == 3) || (op == 4)) && addr[0]) ||
                       ((op == 0) && (addr[1:0] != 2'b00)));
`else
        return 1'b0 && ex && (op == 0) && addr[0];
`endif
    endfunction

    // Presents one instruction in EX and holds it until it may advance.
    task automatic issue(input bit we, input int op, input logic [31:0] addr,
                         input logic [31:0] rt, input bit ex, input int stall,
                         input bit exp_resp, output int cyc);
        bit ae;
        bit done;
        ae = exp_adr(ex, op, addr);
        if (!ex && !ae) begin
            req_q.push_back(model(we, op, addr, rt));
            resp_q.push_back(exp_resp);
        end
        es_mem_valid = 1'b1;
        es_mem_we    = we;
        es_mem_op    = 3'(op);
        es_addr      = addr;
        es_st_data   = rt;
        es_ex        = ex;
        ms_allowin   = (stall == 0);
        done         = 1'b0;
        cyc          = 0;
        @(negedge clk);
        check("adr_ex", 32'(adr_ex), 32'(ae));
        if (ae) check("adr_exccode", 32'(adr_exccode), we ? 32'h5 : 32'h4);
        for (int t = 0; t < 300 && !done; t++) begin
            if (t > 0) @(negedge clk);
            cyc = t + 1;
            if (data_req && !data_addr_ok)
                check("mem_ready_go_in_req", 32'(mem_ready_go), 32'h0);
            if (mem_ready_go && ms_allowin) begin
                done = 1'b1;
            end else begin
                if (mem_ready_go && stall > 0) stall--;
                @(posedge clk);
                #1;
                ms_allowin = (stall == 0);
            end
        end
        if (!done) fail_now("ex_advance_timeout");
        @(posedge clk);
        #1;
        es_mem_valid = 1'b0;
        es_ex        = 1'b0;
        ms_allowin   = 1'b1;
    endtask

    // Bus slave with programmable addr_ok / data_ok latency.
    initial begin
        bit hs;
        bit pend;
        int acnt;
        int dcnt;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        pend = 1'b0;
        acnt = 0;
        dcnt = 0;
        forever begin
            @(negedge clk);
            hs = data_req && data_addr_ok;
            @(posedge clk);
            #1;
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            if (!resetn) begin
                pend = 1'b0;
            end else begin
                if (hs) begin
                    pend = 1'b1;
                    dcnt = data_dly;
                end else if (pend) begin
                    if (dcnt == 0) begin
                        data_data_ok = 1'b1;
                        pend = 1'b0;
                    end else begin
                        dcnt--;
                    end
                end
            end
            if (!data_req) acnt = addr_dly;
            else if (acnt == 0) data_addr_ok = resetn;
            else acnt--;
        end
    end

    // Monitor: pops expectations on address handshakes and returned data.
    initial begin
        exp_t e;
        bit   expv;
        bit   phold;
        int   req_len;
        logic [31:0] p_addr;
        logic [31:0] p_wdata;
        logic [31:0] p_ctl;
        expv = 1'b0;
        phold = 1'b0;
        req_len = 0;
        p_addr = 32'h0;
        p_wdata = 32'h0;
        p_ctl = 32'h0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                armed = 1'b0;
                outst = 1'b0;
                phold = 1'b0;
                req_len = 0;
                resp_q.delete();
                continue;
            end
            if (armed) check("resp_valid", 32'(resp_valid), 32'(expv));
            else if (resp_valid) check("resp_valid_unexpected", 32'(resp_valid), 32'h0);
            armed = 1'b0;
            if (outst) begin
                check("no_overlap_req", 32'(data_req), 32'h0);
                if (data_data_ok) begin
                    outst = 1'b0;
                    if (resp_q.size() == 0) begin
                        check("resp_queue_empty", 32'h0, 32'h1);
                    end else begin
                        expv  = resp_q.pop_front();
                        armed = 1'b1;
                    end
                end
            end
            if (data_req) begin
                req_len++;
                if (phold) begin
                    check("hold_addr", data_addr, p_addr);
                    check("hold_wdata", data_wdata, p_wdata);
                    check("hold_ctl", 32'({data_wr, data_size, data_wstrb}), p_ctl);
                end
            end
            phold   = data_req && !data_addr_ok;
            p_addr  = data_addr;
            p_wdata = data_wdata;
            p_ctl   = 32'({data_wr, data_size, data_wstrb});
            if (data_req && data_addr_ok) begin
                check("mem_ready_go_hs", 32'(mem_ready_go), 32'h1);
                if (req_q.size() == 0) begin
                    check("req_unexpected", data_addr, 32'hFFFF_FFFF);
                end else begin
                    e = req_q.pop_front();
                    check("req_wr", 32'(data_wr), 32'(e.wr));
                    check("req_size", 32'(data_size), 32'(e.size));
                    check("req_addr", data_addr, e.addr);
                    check("req_wstrb", 32'(data_wstrb), 32'(e.wstrb));
                    if (e.wr) check("req_wdata", data_wdata, e.wdata);
                end
                last_req_len = req_len;
                req_len = 0;
                outst = 1'b1;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit got;
        bit we;
        int op;
        resetn       = 1'b0;
        es_mem_valid = 1'b0;
        es_mem_we    = 1'b0;
        es_mem_op    = 3'd0;
        es_addr      = 32'h0;
        es_st_data   = 32'h0;
        es_ex        = 1'b0;
        flush        = 1'b0;
        ms_allowin   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_req", 32'(data_req), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_addr", data_addr, 32'h0);
        check("rst_wdata", data_wdata, 32'h0);
        check("rst_ctl", 32'({data_wr, data_size, data_wstrb}), 32'h0);
        check("rst_adr_ex", 32'(adr_ex), 32'h0);
        check("rst_mem_ready_go", 32'(mem_ready_go), 32'h1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // SB with addr_ok on the second request cycle
        addr_dly = 1;
        data_dly = 1;
        issue(1'b1, 1, 32'h0000_1003, 32'h0000_00A5, 1'b0, 0, 1'b1, cyc);
        check("sb_req_len", 32'(last_req_len), 32'd2);
        check("sb_cycles_to_go", 32'(cyc), 32'd3);

        addr_dly = 0;
        issue(1'b1, 6, 32'h0000_2002, 32'h1122_3344, 1'b0, 0, 1'b1, cyc);

        // LW with MEM stalled: must not re-issue
        data_dly = 0;
        issue(1'b0, 0, 32'h0000_3000, 32'h0, 1'b0, 3, 1'b1, cyc);

        // flush in WAIT drops the response; following SW waits for IDLE
        data_dly = 1;
        issue(1'b0, 0, 32'h0000_3100, 32'h0, 1'b0, 0, 1'b0, cyc);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        issue(1'b1, 0, 32'h0000_3104, 32'hCAFE_F00D, 1'b0, 0, 1'b1, cyc);

        // flush during REQ: request held until addr_ok, response dropped
        addr_dly = 3;
        data_dly = 0;
        req_q.push_back(model(1'b0, 0, 32'h0000_5000, 32'h0));
        resp_q.push_back(1'b0);
        es_mem_valid = 1'b1;
        es_mem_we    = 1'b0;
        es_mem_op    = 3'd0;
        es_addr      = 32'h0000_5000;
        ms_allowin   = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = data_req;
        end
        if (!got) fail_now("flush_req_launch");
        @(posedge clk);
        #1;
        flush = 1'b1;
        es_mem_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("req_held_after_flush", 32'(data_req), 32'h1);
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            got = !data_req && !outst && !armed && (resp_q.size() == 0);
        end
        if (!got) fail_now("flush_req_drain");
        @(posedge clk);
        #1;

        // reset in the middle of WAIT
        addr_dly = 0;
        data_dly = 6;
        issue(1'b0, 0, 32'h0000_6000, 32'h0, 1'b0, 0, 1'b0, cyc);
        resetn = 1'b0;
        #1;
        check("midrst_data_req", 32'(data_req), 32'h0);
        check("midrst_resp_valid", 32'(resp_valid), 32'h0);
        check("midrst_addr", data_addr, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // misaligned accesses (exceptions only when address checking is built in)
        data_dly = 0;
        issue(1'b0, 3, 32'h0000_4001, 32'h0, 1'b0, 0, 1'b1, cyc);
        issue(1'b1, 0, 32'h0000_4002, 32'h1234_5678, 1'b0, 0, 1'b1, cyc);
        issue(1'b1, 5, 32'h0000_4001, 32'hA1B2_C3D4, 1'b0, 0, 1'b1, cyc);
        issue(1'b0, 0, 32'h0000_4000, 32'h0, 1'b1, 0, 1'b1, cyc);

        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            if (we) begin
                case ($urandom_range(0, 4))
                    0: op = 0;
                    1: op = 1;
                    2: op = 3;
                    3: op = 5;
                    default: op = 6;
                endcase
            end else begin
                op = int'($urandom_range(0, 6));
            end
            addr_dly = int'($urandom_range(0, 2));
            data_dly = int'($urandom_range(0, 2));
            issue(we, op, $urandom, $urandom, ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 2)), 1'b1, cyc);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        got = 1'b0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = (req_q.size() == 0) && (resp_q.size() == 0) && !outst && !armed;
        end
        if (!got) fail_now("final_drain");
        check("left_req", 32'(req_q.size()), 32'h0);
        check("left_resp", 32'(resp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
